// File: rtl/burst_memory_pkg.sv
// Shared encodings and helpers for the burst memory.
package burst_memory_pkg;

  typedef enum logic [1:0] {
    AS_1W  = 2'b00,
    AS_4W  = 2'b01,
    AS_8W  = 2'b10,
    AS_16W = 2'b11
  } access_size_e;

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  function automatic logic [4:0] burst_len(input logic [1:0] size);
    logic [4:0] len;
    case (size)
      AS_1W:   len = 5'd1;
      AS_4W:   len = 5'd4;
      AS_8W:   len = 5'd8;
      default: len = 5'd16;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte storage with one word-wide big-endian port; byte indices wrap modulo DEPTH.
module mem_byte_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1048576,
  localparam int unsigned BPW       = DATA_WIDTH / 8,
  localparam int unsigned OFF_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic [OFF_WIDTH-1:0]  offset,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [7:0] mem [DEPTH];

  // Lowest address carries the most significant byte.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < BPW; i++) begin
      rdata[DATA_WIDTH-1-8*i -: 8] = mem[offset + OFF_WIDTH'(i)];
    end
  end

  always_ff @(posedge clock) begin
    if (we) begin
      for (int unsigned i = 0; i < BPW; i++) begin
        mem[offset + OFF_WIDTH'(i)] <= wdata[DATA_WIDTH-1-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/burst_memory.sv
// Big-endian byte-addressable memory with 1/4/8/16-word read and write bursts.
module burst_memory
  import burst_memory_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH      = 1048576,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            access_size,
  input  logic                  rw,
  input  logic                  enable,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  error
);

  localparam int unsigned BPW       = DATA_WIDTH / 8;
  localparam int unsigned OFF_WIDTH = $clog2(DEPTH);

  state_e                state_q, state_d;
  logic [4:0]            count_q, count_d;
  logic [4:0]            len_q, len_d;
  logic                  rw_q, rw_d;
  logic [OFF_WIDTH-1:0]  off_q, off_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;

  logic [ADDR_WIDTH-1:0] full_off;
  logic                  req_ok;
  logic [OFF_WIDTH-1:0]  mem_off;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign full_off = address - START_ADDR;
  assign req_ok   = (full_off < ADDR_WIDTH'(DEPTH)) && ((full_off % ADDR_WIDTH'(BPW)) == '0);

  // Word 0 goes straight from the request address; later words use the running offset.
  assign mem_off = (state_q == BURST) ? off_q : full_off[OFF_WIDTH-1:0];
  assign mem_we  = (state_q == BURST) ? rw_q : (enable && req_ok && rw);

  mem_byte_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clock  (clock),
    .offset (mem_off),
    .wdata  (data_in),
    .we     (mem_we),
    .rdata  (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    rw_d    = rw_q;
    off_d   = off_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          if (!req_ok) begin
            error_d = 1'b1;
          end else begin
            rw_d  = rw;
            len_d = burst_len(access_size);
            off_d = mem_off + OFF_WIDTH'(BPW);
            if (!rw) begin
              data_d  = mem_rdata;
              valid_d = 1'b1;
            end
            if (burst_len(access_size) > 5'd1) begin
              state_d = BURST;
              count_d = 5'd1;
            end
          end
        end
      end
      BURST: begin
        off_d   = off_q + OFF_WIDTH'(BPW);
        count_d = count_q + 5'd1;
        if (!rw_q) begin
          data_d  = mem_rdata;
          valid_d = 1'b1;
        end
        if (count_q == len_q - 5'd1) begin
          state_d = IDLE;
          count_d = 5'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      rw_q    <= 1'b0;
      off_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      rw_q    <= rw_d;
      off_q   <= off_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign busy       = (state_q == BURST);
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign error      = error_q;

endmodule

// File: tb/tb_burst_memory.sv
// Self-checking bench for burst_memory: directed table, reset corner case, random bursts.
module tb_burst_memory;

  localparam int          DEPTH = 1048576;
  localparam logic [31:0] START = 32'h80020000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [1:0]  access_size;
  logic        rw;
  logic        enable;
  logic        busy;
  logic [31:0] data_out;
  logic        data_valid;
  logic        error;

  burst_memory dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .data_in     (data_in),
    .access_size (access_size),
    .rw          (rw),
    .enable      (enable),
    .busy        (busy),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .error       (error)
  );

  always #5 clock = ~clock;

  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] last_data;
  logic [31:0] rd_act [16];
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wr;
    logic [31:0] wbase;
    bit          exp_err;
    int          exp_busy;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tb_len(input logic [1:0] size);
    case (size)
      2'd0:    return 1;
      2'd1:    return 4;
      2'd2:    return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] o);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w = {w[23:0], ref_mem[(o + 32'(i)) % 32'(DEPTH)]};
    return w;
  endfunction

  task automatic model_write(input logic [31:0] o, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ref_mem[(o + 32'(i)) % 32'(DEPTH)] = w[31-8*i -: 8];
  endtask

  // Drives one request, then garbage (opposite-direction enables) while busy.
  task automatic run_burst(input logic [31:0] addr, input logic [1:0] size, input logic wr,
                           input logic [31:0] wbase, input bit seq, output int busy_cnt);
    int          n;
    logic [31:0] off;
    bit          bad;
    logic [31:0] wd;
    n        = tb_len(size);
    off      = addr - START;
    bad      = (off >= 32'(DEPTH)) || (off[1:0] != 2'b00);
    busy_cnt = 0;
    for (int k = 0; k < (bad ? 1 : n); k++) begin
      @(negedge clock);
      wd      = seq ? wbase + 32'(k) : $urandom;
      data_in = wd;
      enable  = 1'b1;
      if (k == 0) begin
        address     = addr;
        access_size = size;
        rw          = wr;
      end else begin
        address     = $urandom;
        access_size = 2'($urandom);
        rw          = ~wr;
      end
      @(posedge clock);
      #1;
      if (!bad && !wr) last_data = model_word(off + 32'(4 * k));
      if (!bad && wr) model_write(off + 32'(4 * k), wd);
      rd_act[k] = data_out;
      check("error", 32'(error), 32'(bad));
      check("busy", 32'(busy), 32'(!bad && (k < n - 1)));
      check("data_valid", 32'(data_valid), 32'(!bad && !wr));
      check("data_out", data_out, last_data);
      if (busy) busy_cnt++;
    end
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      enable      = 1'b0;
      address     = $urandom;
      rw          = 1'($urandom);
      access_size = 2'($urandom);
      @(posedge clock);
      #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(data_valid), 32'd0);
      check("idle_error", 32'(error), 32'd0);
      check("idle_data_out", data_out, last_data);
    end
  endtask

  vec_t        vecs [10];
  int          bc;
  int          r;
  logic [31:0] addr;
  logic [7:0]  b;

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    rw          = 1'b0;
    address     = '0;
    data_in     = '0;
    access_size = '0;
    last_data   = '0;

    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      dut.u_mem.mem[i] = b;
      ref_mem[i] = b;
      b = 8'($urandom);
      dut.u_mem.mem[DEPTH-1-i] = b;
      ref_mem[DEPTH-1-i] = b;
    end
    for (int i = 0; i < 4; i++) begin
      b = 8'h12 + 8'(i * 8'h22);
      dut.u_mem.mem[i] = b;
      ref_mem[i] = b;
    end

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    vecs[0] = '{32'h80020000, 2'b00, 1'b0, 32'h0,        1'b0, 0};
    vecs[1] = '{32'h80020010, 2'b01, 1'b1, 32'hA0000001, 1'b0, 3};
    vecs[2] = '{32'h80020010, 2'b01, 1'b0, 32'h0,        1'b0, 3};
    vecs[3] = '{32'h8011FFF8, 2'b11, 1'b0, 32'h0,        1'b0, 15};
    vecs[4] = '{32'h80020002, 2'b01, 1'b1, 32'hB0000000, 1'b1, 0};
    vecs[5] = '{32'h80000000, 2'b00, 1'b1, 32'hB0000010, 1'b1, 0};
    vecs[6] = '{32'h80120000, 2'b00, 1'b0, 32'h0,        1'b1, 0};
    vecs[7] = '{32'h80020040, 2'b10, 1'b0, 32'h0,        1'b0, 7};
    vecs[8] = '{32'h80020040, 2'b10, 1'b0, 32'h0,        1'b0, 7};
    vecs[9] = '{32'h80020000, 2'b00, 1'b0, 32'h0,        1'b0, 0};

    for (int i = 0; i < 10; i++) begin
      run_burst(vecs[i].addr, vecs[i].size, vecs[i].wr, vecs[i].wbase, 1'b1, bc);
      check($sformatf("busy_cycles[%0d]", i), 32'(bc), 32'(vecs[i].exp_busy));
      if (i == 0 || i == 9) check("preload_word", rd_act[0], 32'h12345678);
      if (i == 2) begin
        for (int k = 0; k < 4; k++) check("raw_word", rd_act[k], 32'hA0000001 + 32'(k));
      end
      idle(1);
    end

    // Reset in the third cycle of a 4-word write.
    @(negedge clock);
    address = 32'h80020100; access_size = 2'b01; rw = 1'b1; enable = 1'b1; data_in = 32'hC0000000;
    @(posedge clock);
    #1;
    model_write(32'h100, 32'hC0000000);
    @(negedge clock);
    data_in = 32'hC0000001;
    enable  = 1'b0;
    @(posedge clock);
    #1;
    model_write(32'h104, 32'hC0000001);
    check("mid_busy", 32'(busy), 32'd1);
    @(negedge clock);
    data_in = 32'hC0000002;
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(data_valid), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    check("arst_data_out", data_out, 32'd0);
    last_data = '0;
    @(negedge clock);
    reset = 1'b0;
    run_burst(32'h80020100, 2'b01, 1'b0, 32'h0, 1'b0, bc);
    check("post_rst_busy_cycles", 32'(bc), 32'd3);
    check("post_rst_w0", rd_act[0], 32'hC0000000);
    check("post_rst_w1", rd_act[1], 32'hC0000001);
    idle(1);

    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) addr = START + 32'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3));
      else if (r == 1) addr = $urandom_range(0, 1) ? START - 32'(4 * $urandom_range(1, 100))
                                                   : START + 32'(DEPTH) + 32'(4 * $urandom_range(0, 100));
      else if (r == 2) addr = START + 32'(DEPTH - 64) + 32'(4 * $urandom_range(0, 15));
      else addr = START + 32'(4 * $urandom_range(0, 1023));
      run_burst(addr, 2'($urandom), 1'($urandom), 32'h0, 1'b0, bc);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_memory.md
Name: burst_memory

Overview:
- Byte-addressable, big-endian instruction/data memory for the MIPS pipeline; successor to the single-word fetch memory.
- Parametrised in word width, depth and base address. Adds multi-word read and write bursts (1/4/8/16 words), a busy handshake, a valid strobe and a range/alignment error flag.
- Sits behind the fetch and memory stages; testbenches preload it hierarchically.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8. BPW = DATA_WIDTH/8 bytes per word.
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 1048576, memory size in bytes; power of two; multiple of BPW.
- START_ADDR, 32'h80020000, byte address mapped to array offset 0.

Ports:
- clock, input, 1, sole clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-high.
- address, input, ADDR_WIDTH, start byte address of the request.
- data_in, input, DATA_WIDTH, write data, sampled every write-burst cycle.
- access_size, input, 2, burst length: 00=1, 01=4, 10=8, 11=16 words.
- rw, input, 1, 1=write, 0=read.
- enable, input, 1, request strobe.
- busy, output, 1, burst in progress; new requests are ignored while high.
- data_out, output, DATA_WIDTH, registered read data.
- data_valid, output, 1, data_out holds a valid read word this cycle.
- error, output, 1, one-cycle pulse when a request is rejected.

Behaviour:
- Reset (async): busy=0, data_valid=0, error=0, data_out=0, internal counters=0. Array contents are not reset.
- Reset mid-burst aborts the burst immediately. Words already written persist.
- Accept edge T0: the posedge with enable=1 and busy=0. At T0 the block latches rw, N=len(access_size), and offset = address - START_ADDR (ADDR_WIDTH modular subtract).
- Reject: if offset >= DEPTH or offset mod BPW != 0:
  - error=1 for the cycle after T0.
  - No array access; busy and data_valid stay 0.
- Read burst: word k (k=0..N-1) is read from offset+k*BPW.
  - It is registered onto data_out at edge T0+k, with data_valid=1 in the following cycle. Read latency is 1 cycle per word.
  - Word layout: data_out = {mem[o], mem[o+1], ..., mem[o+BPW-1]}, MSB byte at the lowest address.
- Write burst: word k is data_in sampled at edge T0+k and written big-endian to offset+k*BPW. data_valid stays 0.
- busy is 1 after edges T0..T0+N-2, and 0 after T0+N-1. For N=1, busy never rises.
- A new request may be accepted on the edge right after busy falls; back-to-back bursts are gapless.
- enable, rw, access_size and address are don't-care while busy=1.
- Wrap-around: the burst offset advances modulo DEPTH. A burst crossing the top of the array continues at offset 0 and raises no error; only the start offset is range-checked.
- Between read words data_out holds its last value. data_valid=0 when idle.
- Read-after-write: a read burst accepted after a write burst completes returns the new data. Reads and writes never overlap within one burst.

Decomposition:
- Package burst_memory_pkg holds:
  - access_size encodings: AS_1W, AS_4W, AS_8W, AS_16W.
  - function burst_len(access_size) returning 1/4/8/16.
  - 2-state FSM encoding: IDLE, BURST.
- FSM transitions:
  - IDLE -> BURST on an accepted, valid request with N>1.
  - BURST -> IDLE when the word counter reaches N-1.
- Sub-module mem_byte_array: DEPTH-byte storage with one word-wide big-endian read/write port (offset, wdata, we, rdata). Modulo-DEPTH byte indexing is applied inside it.

Test Plan:
- Preload bytes 0x80020000..03 = 12 34 56 78; read access_size=00 at 0x80020000 -> data_out=0x12345678 with data_valid for exactly 1 cycle; busy stays 0.
- Write burst access_size=01 at 0x80020010 with data 0xA0000001..0xA0000004, then read burst 01 at same address -> 4 consecutive valid words 0xA0000001..04; busy high for 3 cycles in each burst.
- Read 16-word burst at START_ADDR+DEPTH-8 -> words 0,1 come from the top of the array, words 2..15 from offsets 0..55; error stays 0.
- Address 0x80020002 (misaligned) and 0x80000000 (below base) -> error pulse 1 cycle, no write occurs, busy=0, data_valid=0.
- enable pulsed with rw=1 during an active 8-word read -> ignored; read completes all 8 words; memory unchanged.
- Assert reset at the 3rd cycle of a 4-word write -> busy, data_valid and error drop to 0 asynchronously; words 0..1 are written, words 2..3 are not; the next request is accepted normally.
